// File: rtl/corevx_tlb_pkg.sv
// Shared command encodings, controller state enum and field widths for the corevx TLB.
// The optional COREVX_TLB_STATS_EN build adds hit/miss counters to corevx_tlb_ctrl.
package corevx_tlb_pkg;

    localparam int unsigned VPN_W = 20;
    localparam int unsigned PPN_W = 22;
    localparam int unsigned TAG_W = 8;

    typedef enum logic [1:0] {
        TLB_CMD_NONE       = 2'd0,
        TLB_CMD_RESOLVE    = 2'd1,
        TLB_CMD_WRITE      = 2'd2,
        TLB_CMD_INVALIDATE = 2'd3
    } tlb_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWalkReq,
        StWalkWait,
        StRefill
    } tlb_state_e;

endpackage

// File: rtl/corevx_tlb_victim_sel.sv
// Victim chooser: lowest-index invalid way first, otherwise the round-robin pointer.
// The pointer advances on each refill and wraps from WAYS-1 to 0.
module corevx_tlb_victim_sel #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned IDX_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WAYS-1:0]  valid,
    input  logic             advance,
    output logic [IDX_W-1:0] victim,
    output logic [IDX_W-1:0] ptr
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (ptr_q == IDX_W'(WAYS - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_comb begin
        victim = ptr_q;
        found  = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !valid[w]) begin
                victim = IDX_W'(w);
                found  = 1'b1;
            end
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/corevx_tlb_ctrl.sv
// Sequencer for a WAYS-way set-associative TLB: resolve, page-table walk, refill, invalidate-all.
// Define COREVX_TLB_STATS_EN to add saturating hit_count/miss_count outputs.
module corevx_tlb_ctrl
    import corevx_tlb_pkg::*;
#(
    parameter int unsigned WAYS      = 2,
    parameter int unsigned ENTRIES_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [VPN_W-1:0]      req_vaddr,
    output logic                  rsp_valid,
    output logic [PPN_W-1:0]      rsp_phys,
    output logic [TAG_W-1:0]      rsp_accesstag,
    output logic                  rsp_fault,
    input  logic                  inv_valid,
    output logic                  inv_ready,
    output logic                  ptw_req_valid,
    input  logic                  ptw_req_ready,
    output logic [VPN_W-1:0]      ptw_req_vaddr,
    input  logic                  ptw_rsp_valid,
    input  logic [PPN_W-1:0]      ptw_rsp_phys,
    input  logic [TAG_W-1:0]      ptw_rsp_accesstag,
    input  logic                  ptw_rsp_fault,
    output logic [2*WAYS-1:0]     way_command,
    output logic [VPN_W-1:0]      way_vaddr,
    output logic [VPN_W-1:0]      way_vaddr_w,
    output logic [TAG_W-1:0]      way_accesstag_w,
    output logic [PPN_W-1:0]      way_phys_w,
    input  logic [WAYS-1:0]       way_hit,
    input  logic [TAG_W*WAYS-1:0] way_accesstag_r,
    input  logic [PPN_W*WAYS-1:0] way_phys_r
`ifdef COREVX_TLB_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(WAYS);

    tlb_state_e       state_q, state_d;
    logic [VPN_W-1:0] vaddr_q;
    logic [PPN_W-1:0] phys_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] victim_q;
    logic             fault_pend_q;

    logic [IDX_W-1:0] victim;
    logic [IDX_W-1:0] rr_ptr;
    logic [WAYS-1:0]  way_valid;
    logic             any_hit;
    logic             hit_found;
    logic [PPN_W-1:0] hit_phys;
    logic [TAG_W-1:0] hit_tag;
    logic             inv_fire;
    logic             req_fire;
    logic             walk_done;
    logic             walk_bad;
    logic             unused_cfg;

    // Set indexing lives in the ways; the pointer is exported only for observability.
    assign unused_cfg = ^{rr_ptr, ENTRIES_W};

    assign inv_fire  = (state_q == StIdle) && inv_valid;
    assign req_fire  = (state_q == StIdle) && !inv_valid && req_valid;
    assign walk_done = (state_q == StWalkWait) && ptw_rsp_valid;
    assign walk_bad  = ptw_rsp_fault || !ptw_rsp_accesstag[0];
    assign any_hit   = |way_hit;

    always_comb begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            way_valid[w] = way_accesstag_r[w*TAG_W];
        end
    end

    // Lowest-index hitting way supplies the response.
    always_comb begin
        hit_found = 1'b0;
        hit_phys  = '0;
        hit_tag   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit_found && way_hit[w]) begin
                hit_found = 1'b1;
                hit_phys  = way_phys_r[w*PPN_W +: PPN_W];
                hit_tag   = way_accesstag_r[w*TAG_W +: TAG_W];
            end
        end
    end

    corevx_tlb_victim_sel #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_victim_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (way_valid),
        .advance (state_q == StRefill),
        .victim  (victim),
        .ptr     (rr_ptr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (req_fire) state_d = StLookup;
            StLookup:   state_d = any_hit ? StIdle : StWalkReq;
            StWalkReq:  if (ptw_req_ready) state_d = StWalkWait;
            StWalkWait: if (ptw_rsp_valid) state_d = walk_bad ? StIdle : StRefill;
            StRefill:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vaddr_q      <= '0;
            phys_q       <= '0;
            tag_q        <= '0;
            victim_q     <= '0;
            fault_pend_q <= 1'b0;
        end else begin
            if (req_fire) vaddr_q <= req_vaddr;
            if (state_q == StLookup && !any_hit) victim_q <= victim;
            if (walk_done) begin
                phys_q <= ptw_rsp_phys;
                tag_q  <= ptw_rsp_accesstag;
            end
            // A faulting walk reports from IDLE in the following cycle.
            fault_pend_q <= walk_done && walk_bad;
        end
    end

    always_comb begin
        req_ready       = 1'b0;
        inv_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_phys        = '0;
        rsp_accesstag   = '0;
        rsp_fault       = 1'b0;
        ptw_req_valid   = 1'b0;
        ptw_req_vaddr   = '0;
        way_command     = '0;
        way_vaddr       = '0;
        way_vaddr_w     = '0;
        way_accesstag_w = '0;
        way_phys_w      = '0;
        unique case (state_q)
            StIdle: begin
                rsp_valid = fault_pend_q;
                rsp_fault = fault_pend_q;
                if (inv_valid) begin
                    inv_ready = 1'b1;
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        way_command[2*w +: 2] = TLB_CMD_INVALIDATE;
                    end
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        way_vaddr = req_vaddr;
                        for (int unsigned w = 0; w < WAYS; w++) begin
                            way_command[2*w +: 2] = TLB_CMD_RESOLVE;
                        end
                    end
                end
            end
            StLookup: begin
                if (any_hit) begin
                    rsp_valid     = 1'b1;
                    rsp_phys      = hit_phys;
                    rsp_accesstag = hit_tag;
                end
            end
            StWalkReq: begin
                ptw_req_valid = 1'b1;
                ptw_req_vaddr = vaddr_q;
            end
            StWalkWait: begin
            end
            StRefill: begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (victim_q == IDX_W'(w)) way_command[2*w +: 2] = TLB_CMD_WRITE;
                end
                way_vaddr_w     = vaddr_q;
                way_accesstag_w = tag_q;
                way_phys_w      = phys_q;
                rsp_valid       = 1'b1;
                rsp_phys        = phys_q;
                rsp_accesstag   = tag_q;
            end
            default: begin
            end
        endcase
    end

`ifdef COREVX_TLB_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || inv_fire) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StLookup) begin
            if (any_hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else if (miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
